acc_dma_core: RTL and testbench

- Parametrised successor of the accelerator-domain core stub.
- Drives the same single-port memory interface (en/we/addr/wdata/rdata/stall) with real traffic.
- Executes one command at a time in one of three modes: COPY (src to dst), FILL (constant to dst) or SUM (reduce src words to a sum).
- Sits between the accelerator command logic and the accelerator-local memory.

---
 rtl/acc_dma_pkg.sv | 27 ++
 rtl/acc_dma_addr_gen.sv | 48 ++++
 rtl/acc_dma_core.sv | 174 +++++++++++++++++
 tb/tb_acc_dma_core.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_dma_pkg.sv
// Shared encodings for the accelerator DMA core: command modes, FSM states, word geometry.
// Pure declarations; no logic, no latency.
package acc_dma_pkg;

    typedef enum logic [1:0] {
        MODE_COPY = 2'd0,
        MODE_FILL = 2'd1,
        MODE_SUM  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RCAP = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int MEM_DATA_SIZE_DEF = 32;
    localparam int BYTES_PER_WORD    = MEM_DATA_SIZE_DEF / 8;

    function automatic int bytes_per_word(input int data_size);
        return data_size / 8;
    endfunction

endpackage

// File: rtl/acc_dma_addr_gen.sv
// Source/destination pointers, word counter and last-word compare for one command.
// Registers update one cycle after load/increment strobes; no backpressure of its own.
module acc_dma_addr_gen
    import acc_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int STEP   = BYTES_PER_WORD
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              src_inc,
    input  logic              dst_inc,
    input  logic              cnt_inc,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [LEN_W-1:0]  count,
    output logic              last
);

    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            src   <= '0;
            dst   <= '0;
            count <= '0;
            len_q <= '0;
        end else if (load) begin
            src   <= src_in;
            dst   <= dst_in;
            count <= '0;
            len_q <= len_in;
        end else begin
            if (src_inc) src   <= src + ADDR_W'(STEP);
            if (dst_inc) dst   <= dst + ADDR_W'(STEP);
            if (cnt_inc) count <= count + LEN_W'(1);
        end
    end

    // True while the word being completed this cycle is the final one.
    assign last = (count + LEN_W'(1)) == len_q;

endmodule

// File: rtl/acc_dma_core.sv
// Single-command DMA engine (COPY / FILL / SUM) on a one-outstanding single-port memory.
// COPY 3, SUM 2, FILL 1 cycle/word unstalled; mem_stall_i holds the request and defers abort.
module acc_dma_core
    import acc_dma_pkg::*;
#(
    parameter int MEM_DATA_SIZE = 32,
    parameter int MEM_ADDR_SIZE = 32,
    parameter int LEN_SIZE      = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [1:0]                 cmd_mode_i,
    input  logic [MEM_ADDR_SIZE-1:0]   cmd_src_i,
    input  logic [MEM_ADDR_SIZE-1:0]   cmd_dst_i,
    input  logic [LEN_SIZE-1:0]        cmd_len_i,
    input  logic [MEM_DATA_SIZE-1:0]   cmd_fill_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [MEM_DATA_SIZE-1:0]   result_o,
    output logic [LEN_SIZE-1:0]        count_o,
    output logic                       mem_en_o,
    output logic [MEM_DATA_SIZE/8-1:0] mem_we_o,
    output logic [MEM_ADDR_SIZE-1:0]   mem_addr_o,
    output logic [MEM_DATA_SIZE-1:0]   mem_wdata_o,
    input  logic [MEM_DATA_SIZE-1:0]   mem_rdata_i,
    input  logic                       mem_stall_i
);

    localparam int BPW = bytes_per_word(MEM_DATA_SIZE);

    state_e                   state, state_nxt;
    mode_e                    mode_q, cmd_mode;
    logic [MEM_DATA_SIZE-1:0] fill_q, data_q, result_q;
    logic                     err_q, abort_q, abort_any;
    logic                     load, src_inc, dst_inc, cnt_inc, cap_copy, cap_sum, err_set;
    logic [MEM_ADDR_SIZE-1:0] src, dst;
    logic [LEN_SIZE-1:0]      count;
    logic                     last;

    assign cmd_mode  = mode_e'(cmd_mode_i);
    // A stalled request defers abort; the remembered request is acted on at acceptance.
    assign abort_any = abort_q | abort_i;

    acc_dma_addr_gen #(
        .ADDR_W (MEM_ADDR_SIZE),
        .LEN_W  (LEN_SIZE),
        .STEP   (BPW)
    ) u_addr_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load    (load),
        .src_in  (cmd_src_i),
        .dst_in  (cmd_dst_i),
        .len_in  (cmd_len_i),
        .src_inc (src_inc),
        .dst_inc (dst_inc),
        .cnt_inc (cnt_inc),
        .src     (src),
        .dst     (dst),
        .count   (count),
        .last    (last)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        src_inc   = 1'b0;
        dst_inc   = 1'b0;
        cnt_inc   = 1'b0;
        cap_copy  = 1'b0;
        cap_sum   = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    load = 1'b1;
                    if (cmd_len_i == '0) begin
                        state_nxt = ST_DONE;
                    end else if (cmd_mode == MODE_RSVD) begin
                        state_nxt = ST_DONE;
                        err_set   = 1'b1;
                    end else if (cmd_mode == MODE_FILL) begin
                        state_nxt = ST_WR;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (!mem_stall_i) begin
                    src_inc   = 1'b1;
                    state_nxt = ST_RCAP;
                end
            end
            ST_RCAP: begin
                if (mode_q == MODE_SUM) begin
                    cap_sum = 1'b1;
                    cnt_inc = 1'b1;
                    if (abort_any) begin
                        state_nxt = ST_DONE;
                        err_set   = 1'b1;
                    end else begin
                        state_nxt = last ? ST_DONE : ST_RD;
                    end
                end else begin
                    cap_copy = 1'b1;
                    if (abort_any) begin
                        state_nxt = ST_DONE;
                        err_set   = 1'b1;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (!mem_stall_i) begin
                    dst_inc = 1'b1;
                    cnt_inc = 1'b1;
                    if (abort_any) begin
                        state_nxt = ST_DONE;
                        err_set   = 1'b1;
                    end else if (last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = (mode_q == MODE_FILL) ? ST_WR : ST_RD;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_COPY;
            fill_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                mode_q <= cmd_mode;
                fill_q <= cmd_fill_i;
            end
            if (load || err_set) err_q <= err_set;
            if (state == ST_RD || state == ST_RCAP || state == ST_WR) abort_q <= abort_any;
            else                                                       abort_q <= 1'b0;
            if (load && cmd_mode == MODE_SUM) result_q <= '0;
            else if (cap_sum)                 result_q <= result_q + mem_rdata_i;
            if (cap_copy) data_q <= mem_rdata_i;
        end
    end

    assign cmd_ready_o = (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);
    assign done_o      = (state == ST_DONE);
    assign err_o       = (state == ST_DONE) && err_q;
    assign result_o    = result_q;
    assign count_o     = count;
    assign mem_en_o    = (state == ST_RD) || (state == ST_WR);
    assign mem_we_o    = (state == ST_WR) ? '1 : '0;
    assign mem_addr_o  = (state == ST_RD) ? src : ((state == ST_WR) ? dst : '0);
    assign mem_wdata_o = (state != ST_WR)     ? '0 :
                         (mode_q == MODE_FILL) ? fill_q : data_q;

endmodule

// File: tb/tb_acc_dma_core.sv
// Scoreboard bench for acc_dma_core: a word-addressed memory model with programmable stall,
// expected reads/writes/completions queued at stimulus time and popped as the DUT produces them.
module tb_acc_dma_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_mode;
    logic [31:0] cmd_src, cmd_dst, cmd_fill;
    logic [15:0] cmd_len;
    logic        abort, busy, done, err;
    logic [31:0] result;
    logic [15:0] count;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_stall;

    always #5 clk = ~clk;

    acc_dma_core #(.MEM_DATA_SIZE(32), .MEM_ADDR_SIZE(32), .LEN_SIZE(16)) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_mode_i  (cmd_mode),
        .cmd_src_i   (cmd_src),
        .cmd_dst_i   (cmd_dst),
        .cmd_len_i   (cmd_len),
        .cmd_fill_i  (cmd_fill),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .result_o    (result),
        .count_o     (count),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_stall_i (mem_stall)
    );

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic err; logic [15:0] cnt; logic [31:0] res; } done_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    done_t       exp_done[$];
    logic [31:0] exp_res = '0;
    logic [31:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: stalls request number stall_idx (0-based within a command) for stall_len cycles.
    int stall_idx = -1;
    int stall_len = 0;
    int req_idx   = 0;
    int stall_cnt = 0;

    assign mem_stall = mem_en && (req_idx == stall_idx) && (stall_cnt < stall_len);

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            req_idx   <= 0;
            stall_cnt <= 0;
        end else if (mem_en) begin
            if (mem_stall) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                req_idx <= req_idx + 1;
                if (mem_we == 4'h0) mem_rdata <= mem[mem_addr[11:2]];
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_we;
    wr_t         mon_w;
    logic [31:0] mon_r;
    done_t       mon_d;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_hold_en",    64'(mem_en),    64'd1);
                chk("stall_hold_addr",  64'(mem_addr),  64'(prev_addr));
                chk("stall_hold_wdata", 64'(mem_wdata), 64'(prev_wdata));
                chk("stall_hold_we",    64'(mem_we),    64'(prev_we));
            end
            if (mem_en && !mem_stall) begin
                if (mem_we != 4'h0) begin
                    if (exp_wr.size() == 0) chk("wr_unexpected", 64'(exp_wr.size()), 64'd1);
                    else begin
                        mon_w = exp_wr.pop_front();
                        chk("wr_addr", 64'(mem_addr),  64'(mon_w.addr));
                        chk("wr_data", 64'(mem_wdata), 64'(mon_w.data));
                        chk("wr_we",   64'(mem_we),    64'hF);
                    end
                end else begin
                    if (exp_rd.size() == 0) chk("rd_unexpected", 64'(exp_rd.size()), 64'd1);
                    else begin
                        mon_r = exp_rd.pop_front();
                        chk("rd_addr", 64'(mem_addr), 64'(mon_r));
                    end
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", 64'(exp_done.size()), 64'd1);
                else begin
                    mon_d = exp_done.pop_front();
                    chk("done_err",    64'(err),    64'(mon_d.err));
                    chk("done_count",  64'(count),  64'(mon_d.cnt));
                    chk("done_result", 64'(result), 64'(mon_d.res));
                    chk("done_busy",   64'(busy),   64'd1);
                end
            end
        end
        prev_stall = mem_stall && !rst;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_we    = mem_we;
    end

    task automatic check_reset(input string name);
        chk({name, "_ready"},  64'(cmd_ready), 64'd1);
        chk({name, "_busy"},   64'(busy),      64'd0);
        chk({name, "_done"},   64'(done),      64'd0);
        chk({name, "_err"},    64'(err),       64'd0);
        chk({name, "_result"}, 64'(result),    64'd0);
        chk({name, "_count"},  64'(count),     64'd0);
        chk({name, "_en"},     64'(mem_en),    64'd0);
        chk({name, "_we"},     64'(mem_we),    64'd0);
        chk({name, "_addr"},   64'(mem_addr),  64'd0);
        chk({name, "_wdata"},  64'(mem_wdata), 64'd0);
    endtask

    task automatic push_expect(input logic [1:0] mode, input logic [31:0] src, input logic [31:0] dst,
                               input logic [31:0] fill, input int n_words, input bit exp_err);
        wr_t         w;
        done_t       d;
        logic [31:0] a_src, a_dst;
        if (mode == 2'd2) exp_res = '0;
        for (int i = 0; i < n_words; i++) begin
            a_src = src + 32'(4 * i);
            a_dst = dst + 32'(4 * i);
            case (mode)
                2'd0: begin
                    exp_rd.push_back(a_src);
                    w.addr = a_dst;
                    w.data = mem[a_src[11:2]];
                    exp_wr.push_back(w);
                end
                2'd1: begin
                    w.addr = a_dst;
                    w.data = fill;
                    exp_wr.push_back(w);
                end
                2'd2: begin
                    exp_rd.push_back(a_src);
                    exp_res = exp_res + mem[a_src[11:2]];
                end
                default: ;
            endcase
        end
        d.err = exp_err;
        d.cnt = 16'(n_words);
        d.res = exp_res;
        exp_done.push_back(d);
    endtask

    task automatic drive_cmd(input logic [1:0] mode, input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] len, input logic [31:0] fill);
        @(negedge clk);
        cmd_mode  = mode;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
    endtask

    task automatic run_cmd(input string name, input logic [1:0] mode, input logic [31:0] src,
                           input logic [31:0] dst, input logic [15:0] len, input logic [31:0] fill,
                           input int n_words, input bit exp_err, input int exp_lat,
                           input bit abort_on_stall);
        int lat;
        bit seen;
        push_expect(mode, src, dst, fill, n_words, exp_err);
        drive_cmd(mode, src, dst, len, fill);
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 200 && !seen; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (abort_on_stall && mem_stall) abort = 1'b1;
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        if (exp_lat > 0) chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        abort = 1'b0;
        @(negedge clk);
        chk({name, "_drain_rd"},   64'(exp_rd.size()),   64'd0);
        chk({name, "_drain_wr"},   64'(exp_wr.size()),   64'd0);
        chk({name, "_drain_done"}, 64'(exp_done.size()), 64'd0);
        chk({name, "_idle_ready"}, 64'(cmd_ready),       64'd1);
        chk({name, "_idle_busy"},  64'(busy),            64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++)    mem[32'h40 + i] = 32'(i + 1);
        for (int i = 0; i < 8; i++)    mem[32'hC0 + i] = 32'hA000 + 32'(i);
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'h0000_0002;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = '0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        cmd_fill  = '0;
        abort     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        run_cmd("copy", 2'd0, 32'h100, 32'h200, 16'd4, 32'h0, 4, 1'b0, 13, 1'b0);

        stall_idx = 1;
        stall_len = 2;
        run_cmd("fill", 2'd1, 32'h0, 32'h40, 16'd3, 32'hDEAD_BEEF, 3, 1'b0, 6, 1'b0);
        stall_idx = -1;

        run_cmd("sum",  2'd2, 32'h0,   32'h0,   16'd2, 32'h0, 2, 1'b0, 5, 1'b0);
        run_cmd("len0", 2'd0, 32'h100, 32'h200, 16'd0, 32'h0, 0, 1'b0, 1, 1'b0);
        run_cmd("rsvd", 2'd3, 32'h100, 32'h200, 16'd5, 32'h0, 0, 1'b1, 1, 1'b0);

        stall_idx = 5;
        stall_len = 3;
        run_cmd("abort", 2'd0, 32'h300, 32'h400, 16'd8, 32'h0, 3, 1'b1, 0, 1'b1);
        stall_idx = -1;

        // Reset in the middle of a long FILL, then a fresh command.
        push_expect(2'd1, 32'h0, 32'h500, 32'h5A5A_5A5A, 10, 1'b0);
        drive_cmd(2'd1, 32'h0, 32'h500, 16'd10, 32'h5A5A_5A5A);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
        exp_done.delete();
        exp_res = '0;

        run_cmd("post", 2'd0, 32'h100, 32'h600, 16'd2, 32'h0, 2, 1'b0, 7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
